alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin valid/ready front end that time-shares one combinational ALU between two
// requesters: grant in IDLE, let the ALU evaluate in EXEC, hold the result in RESP.
module alu_arbiter #(
    parameter int unsigned         DATA_WIDTH = 32,
    parameter int unsigned         OP_WIDTH   = 6,
    parameter logic [OP_WIDTH-1:0] OP_ALU_NOP = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic [OP_WIDTH-1:0]   i_req0_op,
    input  logic [DATA_WIDTH-1:0] i_req0_a,
    input  logic [DATA_WIDTH-1:0] i_req0_b,
    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic [OP_WIDTH-1:0]   i_req1_op,
    input  logic [DATA_WIDTH-1:0] i_req1_a,
    input  logic [DATA_WIDTH-1:0] i_req1_b,
    output logic                  o_rsp0_valid,
    input  logic                  i_rsp0_ready,
    output logic                  o_rsp1_valid,
    input  logic                  i_rsp1_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    input  logic [DATA_WIDTH-1:0] i_alu_c,
    output logic                  o_busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e state_q, state_d;
    logic   owner_q;
    logic   last_q;
    logic   grant0, grant1;
    logic   handshake;
    logic   rsp_ack;

    // On a tie the requester that was not served last wins.
    assign grant0    = i_req0_valid & (~i_req1_valid | last_q);
    assign grant1    = i_req1_valid & (~i_req0_valid | ~last_q);
    assign handshake = (state_q == StIdle) & (grant0 | grant1);
    assign rsp_ack   = (state_q == StResp) & (owner_q ? i_rsp1_ready : i_rsp0_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (handshake) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_req0_ready = (state_q == StIdle) & grant0;
        o_req1_ready = (state_q == StIdle) & grant1;
        o_rsp0_valid = (state_q == StResp) & ~owner_q;
        o_rsp1_valid = (state_q == StResp) & owner_q;
        o_busy       = (state_q != StIdle);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            o_alu_op   <= OP_ALU_NOP;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_rsp_data <= '0;
        end else begin
            if (handshake) begin
                owner_q  <= grant1;
                last_q   <= grant1;
                o_alu_op <= grant1 ? i_req1_op : i_req0_op;
                o_alu_a  <= grant1 ? i_req1_a : i_req0_a;
                o_alu_b  <= grant1 ? i_req1_b : i_req0_b;
            end
            if (state_q == StExec) begin
                o_rsp_data <= i_alu_c;
            end
            // Operands are left in place; only the opcode is parked.
            if (rsp_ack) begin
                o_alu_op <= OP_ALU_NOP;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-requester drivers feed queued requests, a monitor
// compares every presented response against hand-computed expectations.
module tb_alu_arbiter;

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_SLL = 6'd4;
    localparam logic [5:0] OP_SRA = 6'd5;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req0_valid, o_req0_ready, i_req1_valid, o_req1_ready;
    logic [5:0]  i_req0_op, i_req1_op, o_alu_op;
    logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic        o_rsp0_valid, i_rsp0_ready, o_rsp1_valid, i_rsp1_ready;
    logic [31:0] o_rsp_data, o_alu_a, o_alu_b, i_alu_c;
    logic        o_busy;

    req_t q0[$];
    req_t q1[$];
    exp_t exp_q[$];
    logic glog_who[$];
    int   glog_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    alu_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_op(i_req0_op), .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_op(i_req1_op), .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
        .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
        .o_rsp_data(o_rsp_data), .o_alu_op(o_alu_op), .o_alu_a(o_alu_a),
        .o_alu_b(o_alu_b), .i_alu_c(i_alu_c), .o_busy(o_busy)
    );

    function automatic logic [31:0] alu_model(logic [5:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_OR:   return a | b;
            OP_SLL:  return a << b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'h0;
        endcase
    endfunction

    assign i_alu_c = alu_model(o_alu_op, o_alu_a, o_alu_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Requester 0 driver: presents the queue head until it is accepted.
    initial begin
        i_req0_valid = 1'b0; i_req0_op = OP_NOP; i_req0_a = '0; i_req0_b = '0;
        forever begin
            @(posedge i_clk); #1;
            if (q0.size() > 0) begin
                i_req0_valid = 1'b1;
                i_req0_op = q0[0].op; i_req0_a = q0[0].a; i_req0_b = q0[0].b;
            end else begin
                i_req0_valid = 1'b0;
            end
            @(negedge i_clk);
            if (i_req0_valid && o_req0_ready) begin
                void'(q0.pop_front());
                glog_who.push_back(1'b0);
                glog_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        i_req1_valid = 1'b0; i_req1_op = OP_NOP; i_req1_a = '0; i_req1_b = '0;
        forever begin
            @(posedge i_clk); #1;
            if (q1.size() > 0) begin
                i_req1_valid = 1'b1;
                i_req1_op = q1[0].op; i_req1_a = q1[0].a; i_req1_b = q1[0].b;
            end else begin
                i_req1_valid = 1'b0;
            end
            @(negedge i_clk);
            if (i_req1_valid && o_req1_ready) begin
                void'(q1.pop_front());
                glog_who.push_back(1'b1);
                glog_cyc.push_back(cyc);
            end
        end
    end

    task automatic handle_rsp(input logic who, input logic rdy);
        if (exp_q.size() == 0) begin
            check("unexpected_rsp", {63'd0, who}, 64'hdead);
        end else begin
            check("rsp_owner", {63'd0, who}, {63'd0, exp_q[0].who});
            check("rsp_data", {32'd0, o_rsp_data}, {32'd0, exp_q[0].data});
            if (rdy) void'(exp_q.pop_front());
        end
    endtask

    // Monitor: protocol invariants every cycle, scoreboard compare on each presented response.
    initial begin
        forever begin
            @(negedge i_clk);
            check("ready_both", {63'd0, o_req0_ready & o_req1_ready}, 64'd0);
            check("ready_outside_idle", {63'd0, (o_req0_ready | o_req1_ready) & o_busy}, 64'd0);
            check("rsp_valid_both", {63'd0, o_rsp0_valid & o_rsp1_valid}, 64'd0);
            if (o_rsp0_valid) handle_rsp(1'b0, i_rsp0_ready);
            if (o_rsp1_valid) handle_rsp(1'b1, i_rsp1_ready);
        end
    end

    task automatic wait_grants(input int n);
        int k;
        for (k = 0; k < 100; k++) begin
            @(negedge i_clk); #1;
            if (glog_who.size() >= n) break;
        end
        if (k == 100) check("grant_timeout", 64'(glog_who.size()), 64'(n));
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge i_clk); #1;
            if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && !o_busy) break;
        end
        if (k == 300) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
        check({tag, "_alu_op"}, {58'd0, o_alu_op}, {58'd0, OP_NOP});
        check({tag, "_alu_a"}, {32'd0, o_alu_a}, 64'd0);
        check({tag, "_alu_b"}, {32'd0, o_alu_b}, 64'd0);
        check({tag, "_rsp_data"}, {32'd0, o_rsp_data}, 64'd0);
        check({tag, "_valids"}, {62'd0, o_rsp0_valid, o_rsp1_valid}, 64'd0);
        check({tag, "_readies"}, {62'd0, o_req0_ready, o_req1_ready}, 64'd0);
    endtask

    initial begin
        int base;
        i_rst_n = 1'b0;
        i_rsp0_ready = 1'b1;
        i_rsp1_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check_reset_values("por");
        i_rst_n = 1'b1;

        // Tie right after reset: req0 first, req1 three cycles later.
        base = glog_who.size();
        q0.push_back('{OP_SUB, 32'd1, 32'd1});
        q1.push_back('{OP_OR, 32'h101, 32'h10001});
        exp_q.push_back('{1'b0, 32'h0});
        exp_q.push_back('{1'b1, 32'h00010101});
        wait_drain();
        if (glog_who.size() >= base + 2) begin
            check("tie_first", {63'd0, glog_who[base]}, 64'd0);
            check("tie_second", {63'd0, glog_who[base+1]}, 64'd1);
            check("tie_spacing", 64'(glog_cyc[base+1] - glog_cyc[base]), 64'd3);
        end else begin
            check("tie_grants", 64'(glog_who.size()), 64'(base + 2));
        end

        // Continuous contention: strict alternation starting with req0.
        base = glog_who.size();
        q0.push_back('{OP_ADD, 32'd2, 32'd3});
        q0.push_back('{OP_SUB, 32'd10, 32'd4});
        q0.push_back('{OP_OR, 32'hF0, 32'h0F});
        q1.push_back('{OP_SLL, 32'd1, 32'd4});
        q1.push_back('{OP_SRA, 32'h80000000, 32'd1});
        q1.push_back('{OP_ADD, 32'h7FFFFFFF, 32'd1});
        exp_q.push_back('{1'b0, 32'h5});
        exp_q.push_back('{1'b1, 32'h10});
        exp_q.push_back('{1'b0, 32'h6});
        exp_q.push_back('{1'b1, 32'hC0000000});
        exp_q.push_back('{1'b0, 32'hFF});
        exp_q.push_back('{1'b1, 32'h80000000});
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            if (glog_who.size() > base + i)
                check("alternation", {63'd0, glog_who[base+i]}, 64'(i % 2));
            else
                check("alternation_missing", 64'(glog_who.size()), 64'(base + 6));
        end

        // Single request: exact two-cycle latency.
        base = glog_who.size();
        q0.push_back('{OP_ADD, 32'd1, 32'd1});
        exp_q.push_back('{1'b0, 32'h2});
        wait_grants(base + 1);
        @(negedge i_clk); #1;
        check("single_t1_alu_op", {58'd0, o_alu_op}, {58'd0, OP_ADD});
        check("single_t1_busy", {63'd0, o_busy}, 64'd1);
        @(negedge i_clk); #1;
        check("single_t2_rsp0", {63'd0, o_rsp0_valid}, 64'd1);
        check("single_t2_rsp1", {63'd0, o_rsp1_valid}, 64'd0);
        check("single_t2_data", {32'd0, o_rsp_data}, 64'h2);
        wait_drain();

        // Backpressure on req1 for four RESP cycles while req0 waits.
        i_rsp1_ready = 1'b0;
        base = glog_who.size();
        q1.push_back('{OP_SRA, 32'hFFFFFFF0, 32'd3});
        exp_q.push_back('{1'b1, 32'hFFFFFFFE});
        wait_grants(base + 1);
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        check("bp_rsp1_valid", {63'd0, o_rsp1_valid}, 64'd1);
        q0.push_back('{OP_ADD, 32'd5, 32'd6});
        exp_q.push_back('{1'b0, 32'hB});
        repeat (3) begin
            @(negedge i_clk); #1;
            check("bp_hold_valid", {63'd0, o_rsp1_valid}, 64'd1);
            check("bp_no_grant", {63'd0, o_req0_ready}, 64'd0);
            check("bp_data_stable", {32'd0, o_rsp_data}, 64'hFFFFFFFE);
        end
        @(posedge i_clk); #1;
        i_rsp1_ready = 1'b1;
        @(negedge i_clk); #1;
        @(negedge i_clk); #1;
        check("bp_idle_after", {63'd0, o_busy}, 64'd0);
        check("bp_req0_ready", {63'd0, o_req0_ready}, 64'd1);
        wait_drain();

        // Reset during EXEC drops the transaction; afterwards req0 wins the tie again.
        base = glog_who.size();
        q0.push_back('{OP_SLL, 32'd1, 32'h10});
        wait_grants(base + 1);
        @(posedge i_clk); #1;
        check("exec_busy", {63'd0, o_busy}, 64'd1);
        i_rst_n = 1'b0;
        #1;
        check_reset_values("mid");
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        base = glog_who.size();
        q0.push_back('{OP_ADD, 32'd3, 32'd4});
        q1.push_back('{OP_ADD, 32'd8, 32'd9});
        exp_q.push_back('{1'b0, 32'h7});
        exp_q.push_back('{1'b1, 32'h11});
        wait_drain();
        if (glog_who.size() >= base + 2) begin
            check("post_reset_first", {63'd0, glog_who[base]}, 64'd0);
            check("post_reset_second", {63'd0, glog_who[base+1]}, 64'd1);
        end else begin
            check("post_reset_grants", 64'(glog_who.size()), 64'(base + 2));
        end

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
